// File: rtl/dlx_pkg.sv
// Shared DLX definitions: multiply/divide op encodings, sequencer states and
// the divide-by-zero result pattern.
package dlx_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [31:0] DIV0_RESULT = '1;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One shift/add (multiply) or restoring shift/subtract (divide) step per
// step strobe on unsigned magnitudes; the sequencer handles signs.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] res
);

  // acc: product accumulator or partial remainder.
  // opa: multiplicand (shifts left) or dividend shifting out / quotient shifting in.
  // opb: multiplier (shifts right) or fixed divisor.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    rem_sh = {acc_q, opa_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opb_q};
    if (load) begin
      acc_d = '0;
      opa_d = a_mag;
      opb_d = b_mag;
    end else if (step) begin
      if (is_div) begin
        // Remainder stays below the divisor, so it always fits WIDTH bits.
        acc_d = diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], ~diff[WIDTH+1]};
      end else begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign res = is_div ? opa_q : acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer with start/busy/done handshake,
// cancel (pipeline flush) and divide-by-zero detection.
module muldiv_seq
  import dlx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             core_load, core_step, is_div, is_signed;
  logic [WIDTH-1:0] a_mag, b_mag, core_res;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign a_mag     = (is_signed && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
  assign b_mag     = (is_signed && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .step  (core_step),
    .is_div(is_div),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .res   (core_res)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    core_load = 1'b0;
    core_step = 1'b0;
    // Cancel squashes any in-flight op before it can touch result/div_by_zero.
    if (cancel && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            state_d = PREP;
            op_d    = op_e'(op);
            a_d     = a;
            b_d     = b;
            dbz_d   = 1'b0;
          end
        end
        PREP: begin
          core_load = 1'b1;
          neg_d     = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          if (is_div && (b_q == '0)) begin
            state_d  = DONE;
            result_d = '1;
            dbz_d    = 1'b1;
          end else begin
            state_d = ITER;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
        ITER: begin
          core_step = 1'b1;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FIX: begin
          result_d = neg_q ? ('0 - core_res) : core_res;
          state_d  = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected results, a
// monitor pops and compares on each done pulse.
module tb_muldiv_seq;
  import dlx_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] result;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.res);
        chk("div_by_zero", div_by_zero, mon_e.dbz);
        chk("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // Start sampled at "edge 0"; cycle n afterwards has cyc == base + n.
  task automatic kick(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      output int base);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    base  = cyc - 1;
    start = 1'b0; op = 2'b00; a = '0; b = '0;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic edbz, input int lat,
                     input int p1, input int p2);
    int base;
    kick(o, x, y, base);
    sbq.push_back('{res: er, dbz: edbz, due: base + lat});
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", n), busy, (n <= lat) ? 1 : 0);
      if (n == p1 || n == p2) begin
        start = 1'b1; op = ~o; a = 32'h1234; b = 32'h5;
      end else begin
        start = 1'b0; op = 2'b00; a = '0; b = '0;
      end
    end
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b0;

    run(OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 35, 0, 0);
    run(OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 35, 5, 35);
    run(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 35, 0, 0);
    run(OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 35, 0, 0);
    run(OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 2,  0, 0);
    chk("dbz_held", div_by_zero, 1);
    chk("dbz_result_held", result, 32'hFFFFFFFF);
    run(OP_DIVU,  32'd9,        32'd3,        32'd3,        1'b0, 35, 0, 0);
    run(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 35, 0, 0);

    // Cancel at cycle 10 of a mult: idle next cycle, no done, result kept.
    kick(OP_MULT, 32'd5, 32'd6, base);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 10) cancel = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_done", done, 0);
    chk("cancel_result", result, 32'h80000000);
    chk("cancel_dbz", div_by_zero, 0);
    repeat (40) @(negedge clk);
    chk("cancel_still_idle", busy, 0);

    // Cancel together with start in IDLE: start dropped.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      chk($sformatf("cancel_start_idle%0d", n), busy, 0);
      @(negedge clk);
    end

    // Reset at cycle 20 of a mult aborts everything.
    kick(OP_MULT, 32'd9, 32'd9, base);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 20) reset = 1'b1;
    end
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    run(OP_MULTU, 32'd3, 32'd4, 32'd12, 1'b0, 35, 0, 0);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
